regfile_dump: RTL and testbench

Sequential reader for the register file's debug port. On a start pulse it walks `debug_addr` over an inclusive register range, captures each `debug_data` value, and streams it out as one word per register on a valid/ready interface. The stream feeds the debug/trace path, for example a UART or log formatter, so register contents can be dumped at run time instead of only at simulation end.

---
 rtl/regfile_dump.sv | 125 ++++++++++++
 tb/tb_regfile_dump.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: sequential reader for the register file debug port.
//
// On a start pulse in IDLE it walks debug_addr over the inclusive range
// [range_lo, range_hi], captures each debug_data value and streams it out as
// one word per register on a valid/ready interface.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start, abort        dump request (IDLE only) / synchronous cancel
//   range_lo, range_hi  inclusive register range, sampled with start
//   busy, done          dump in progress / one-cycle completion pulse
//   debug_addr          registered address to the register file debug port
//   debug_data          raw register contents at debug_addr
//   out_valid/out_ready stream handshake
//   out_data, out_index captured value and its register number
//   out_last            marks the word for range_hi
`timescale 1ns/1ps
module regfile_dump #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int NUM_REGS      = 1 << REGADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [REGADDR_WIDTH-1:0] range_lo,
  input  logic [REGADDR_WIDTH-1:0] range_hi,
  output logic                     busy,
  output logic                     done,
  output logic [REGADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0]    debug_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [REGADDR_WIDTH-1:0] out_index,
  output logic                     out_last
);

  localparam logic [REGADDR_WIDTH-1:0] MAX_IDX = REGADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                     state;
  logic [REGADDR_WIDTH-1:0]   hi_q;
  logic [REGADDR_WIDTH-1:0]   lo_c, hi_c;

  // Bounds past the last register are pulled back onto it.
  always_comb begin
    lo_c = range_lo;
    hi_c = range_hi;
    if (int'(range_lo) >= NUM_REGS) lo_c = MAX_IDX;
    if (int'(range_hi) >= NUM_REGS) hi_c = MAX_IDX;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hi_q       <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      debug_addr <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_index  <= '0;
      out_last   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo_c <= hi_c) begin
              hi_q       <= hi_c;
              debug_addr <= lo_c;
              busy       <= 1'b1;
              state      <= FETCH;
            end else begin
              // Empty range: nothing to stream, just report completion.
              done <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            // debug_data settles during FETCH for the address set last edge.
            out_data  <= debug_data;
            out_index <= debug_addr;
            out_last  <= (debug_addr == hi_q);
            out_valid <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          // Abort wins over a same-cycle handshake; that word is dropped.
          if (abort) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              // Not last implies debug_addr < hi_q, so this never wraps.
              debug_addr <= debug_addr + 1'b1;
              state      <= FETCH;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
`timescale 1ns/1ps
module tb_regfile_dump;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 16;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start, abort, out_ready;
  logic [AW-1:0] range_lo, range_hi, debug_addr, out_index;
  logic [DW-1:0] debug_data, out_data;
  logic          busy, done, out_valid, out_last;

  // Register file with a write port; debug read is combinational.
  logic [DW-1:0] rf [NR];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] mdl [NR];   // expected register contents
  exp_t          sb [$];     // expected stream words

  int n_checks = 0, n_fail = 0, done_cnt = 0, word_cnt = 0, ready_mode = 1;

  regfile_dump #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .range_lo(range_lo), .range_hi(range_hi), .busy(busy), .done(done),
    .debug_addr(debug_addr), .debug_data(debug_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;
  assign debug_data = rf[debug_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready: 0 = low, 1 = high, otherwise random per cycle.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks stall stability.
  initial begin
    logic          stalled;
    logic [DW-1:0] s_data;
    logic [AW-1:0] s_idx;
    logic          s_last;
    exp_t          e;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stalled = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stalled) begin
          check("stall_valid", 32'(out_valid), 32'(1));
          check("stall_data",  32'(out_data),  32'(s_data));
          check("stall_index", 32'(out_index), 32'(s_idx));
          check("stall_last",  32'(out_last),  32'(s_last));
        end
        stalled = out_valid && !out_ready && !abort;
        s_data = out_data; s_idx = out_index; s_last = out_last;
        if (out_valid && out_ready && !abort) begin
          word_cnt++;
          if (sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_word: got index %0d data %0h, required no word", out_index, out_data);
          end else begin
            e = sb.pop_front();
            check("word_index", 32'(out_index), 32'(e.idx));
            check("word_data",  32'(out_data),  32'(e.data));
            check("word_last",  32'(out_last),  32'(e.last));
          end
        end
      end
    end
  end

  // Reference: a dump of [lo,hi] (clamped) yields one word per register in order.
  task automatic push_dump(input int lo, input int hi, output int cnt);
    int l, h;
    exp_t e;
    l = (lo >= NR) ? NR - 1 : lo;
    h = (hi >= NR) ? NR - 1 : hi;
    cnt = 0;
    for (int i = l; i <= h; i++) begin
      e.idx = AW'(i); e.data = mdl[i]; e.last = (i == h);
      sb.push_back(e);
      cnt++;
    end
  endtask

  task automatic preload(input bit rnd);
    for (int i = 0; i < NR; i++) begin
      @(posedge clk); #1;
      wr_en = 1'b1; wr_addr = AW'(i);
      wr_data = rnd ? DW'($urandom) : DW'(100 + i);
      mdl[i] = wr_data;
    end
    @(posedge clk); #1 wr_en = 1'b0;
  endtask

  task automatic do_start(input int lo, input int hi);
    @(posedge clk); #1;
    start = 1'b1; range_lo = AW'(lo); range_hi = AW'(hi);
    @(posedge clk); #1 start = 1'b0;
  endtask

  // n = index of the first negedge after the start edge that shows done.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 300);
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", n);
    end
  endtask

  initial begin
    int n, cnt, w0, d0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_en = 1'b0;
    wr_addr = '0; wr_data = '0; range_lo = '0; range_hi = '0;
    #1;
    check("rst_busy",  32'(busy), 0);
    check("rst_done",  32'(done), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last",  32'(out_last), 0);
    check("rst_addr",  32'(debug_addr), 0);
    check("rst_data",  32'(out_data), 0);
    check("rst_index", 32'(out_index), 0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // Full dump, ready tied high.
    preload(1'b0);
    ready_mode = 1;
    w0 = word_cnt;
    push_dump(0, 15, cnt);
    do_start(0, 15);
    wait_done(n);
    check("full_latency", 32'(n - 1), 32'(32));
    check("full_words", 32'(word_cnt - w0), 32'(16));
    check("full_busy_at_done", 32'(busy), 0);
    @(negedge clk);
    check("full_done_pulse", 32'(done), 0);

    // Partial range, random backpressure.
    ready_mode = 2;
    w0 = word_cnt;
    push_dump(3, 5, cnt);
    do_start(3, 5);
    wait_done(n);
    check("part_words", 32'(word_cnt - w0), 32'(3));
    check("part_sb_empty", 32'(sb.size()), 0);

    // Empty range.
    ready_mode = 1;
    w0 = word_cnt;
    do_start(7, 2);
    wait_done(n);
    check("empty_done_latency", 32'(n), 32'(1));
    check("empty_busy", 32'(busy), 0);
    check("empty_words", 32'(word_cnt - w0), 0);

    // Non-atomic dump: r6 rewritten after r5 is captured; start while busy ignored.
    w0 = word_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; range_lo = 4'd5; range_hi = 4'd6;
    begin
      exp_t e;
      e.idx = 4'd5; e.data = mdl[5]; e.last = 1'b0; sb.push_back(e);
      e.idx = 4'd6; e.data = 16'hBEEF; e.last = 1'b1; sb.push_back(e);
    end
    @(posedge clk); #1 start = 1'b0;               // edge k sampled start
    @(posedge clk); #1;                            // r5 captured at this edge
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 16'hBEEF;
    start = 1'b1; range_lo = 4'd0; range_hi = 4'd15;
    @(posedge clk); #1;
    wr_en = 1'b0; start = 1'b0; mdl[6] = 16'hBEEF;
    wait_done(n);
    repeat (3) @(negedge clk);
    check("beef_words", 32'(word_cnt - w0), 32'(2));
    check("beef_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("beef_sb_empty", 32'(sb.size()), 0);

    // Abort in SEND with a simultaneous ready.
    ready_mode = 0;
    push_dump(0, 15, cnt);
    do_start(0, 15);
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    check("abort_reached_send", 32'(out_valid), 32'(1));
    w0 = word_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b1; ready_mode = 1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    check("abort_valid", 32'(out_valid), 0);
    check("abort_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 0);
    check("abort_no_word", 32'(word_cnt - w0), 0);
    push_dump(0, 0, cnt);
    do_start(0, 0);
    wait_done(n);
    check("single_words", 32'(word_cnt - w0), 32'(1));
    check("single_sb_empty", 32'(sb.size()), 0);

    // Reset asserted mid-dump between edges.
    ready_mode = 2;
    push_dump(0, 15, cnt);
    do_start(0, 15);
    repeat (7) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy",  32'(busy), 0);
    check("mid_rst_done",  32'(done), 0);
    check("mid_rst_addr",  32'(debug_addr), 0);
    sb.delete();
    @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    w0 = word_cnt;
    push_dump(2, 9, cnt);
    do_start(2, 9);
    wait_done(n);
    check("post_rst_words", 32'(word_cnt - w0), 32'(8));

    // Randomized dumps over random contents and ranges.
    for (int it = 0; it < 6; it++) begin
      int lo, hi;
      preload(1'b1);
      lo = $urandom_range(0, NR - 1);
      hi = $urandom_range(0, NR - 1);
      ready_mode = 2;
      w0 = word_cnt;
      push_dump(lo, hi, cnt);
      do_start(lo, hi);
      wait_done(n);
      if (cnt == 0) check("rand_empty_latency", 32'(n), 32'(1));
      check("rand_words", 32'(word_cnt - w0), 32'(cnt));
      check("rand_sb_empty", 32'(sb.size()), 0);
      @(negedge clk);
      check("rand_done_pulse", 32'(done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
